spike_encoder: RTL and testbench

- Rate-coding front end of the SNN inference core. It runs one pass per timestep over the image SRAM read port.
- For each pixel it compares the pixel intensity against a fresh 8-bit pseudo-random value.
- When the random value is below the pixel, it emits that pixel's index as a spike into the spike queue, using a valid/ready handshake.
- The core FSM pulses start_i once per timestep and waits for done_o before starting LOAD_SPIKE processing.

---
 rtl/snn_pkg.sv | 29 ++
 rtl/spike_lfsr8.sv | 22 ++
 rtl/spike_encoder.sv | 129 ++++++++++++
 tb/tb_spike_encoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN inference core: image geometry, LFSR constants,
// spike index type and the encoder state/output types.
package snn_pkg;
  localparam int DIM_X          = 14;
  localparam int DIM_Y          = 14;
  localparam int NUM_PIXELS_DEF = DIM_X * DIM_Y;

  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam logic [7:0] LFSR_RESET = 8'h01;

  localparam int IDX_W = 8;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } enc_state_e;

  typedef struct packed {
    logic vld;
    idx_t idx;
  } spike_t;

  // One Galois step, right-shifting: the bit shifted out selects the tap mask.
  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return r[0] ? ({1'b0, r[7:1]} ^ LFSR_TAPS) : {1'b0, r[7:1]};
  endfunction
endpackage

// File: rtl/spike_lfsr8.sv
// 8-bit Galois LFSR (period 255). Seed load wins over advance; a zero seed
// would lock the register, so it is mapped to the reset value.
module spike_lfsr8
  import snn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed_i,
  input  logic       set_seed_i,
  input  logic       adv_i,
  output logic [7:0] rand_o
);
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst)             lfsr_q <= LFSR_RESET;
    else if (set_seed_i) lfsr_q <= (seed_i == 8'h00) ? LFSR_RESET : seed_i;
    else if (adv_i)      lfsr_q <= lfsr_step(lfsr_q);
  end

  assign rand_o = lfsr_q;
endmodule

// File: rtl/spike_encoder.sv
// Rate-coding spike encoder: one pass over the image SRAM per timestep, emitting
// the index of every pixel whose intensity beats a fresh LFSR value.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int NUM_PIXELS  = NUM_PIXELS_DEF,
  parameter int ADDR_W      = 10,
  parameter int CNT_W       = 9,
  parameter bit FORCE_SPIKE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [7:0]        seed_i,
  input  logic              set_seed_i,
  output logic [ADDR_W-1:0] img_addr_o,
  input  logic [7:0]        img_data_i,
  output logic              spike_valid_o,
  output logic [IDX_W-1:0]  spike_idx_o,
  input  logic              spike_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  spike_count_o
);
  localparam idx_t LAST_IDX = idx_t'(NUM_PIXELS - 1);

  enc_state_e       state_q, state_d;
  idx_t             addr_q;
  logic [1:0]       vld_pipe;   // [0]: address on the bus, [1]: stage-1 pixel data on img_data_i
  idx_t             s1_idx;
  logic             s1_hold;
  logic [7:0]       s1_data;
  spike_t           out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic [7:0] rand_v;
  logic [7:0] pix;
  logic       hit, xfer, stall, adv, start_ok, drain_done;

  spike_lfsr8 u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .seed_i    (seed_i),
    .set_seed_i(set_seed_i),
    .adv_i     (adv),
    .rand_o    (rand_v)
  );

  // The address holds during a stall, so the read port already returns the next
  // pixel; the held pixel's value is kept locally in s1_data instead.
  assign pix        = s1_hold ? s1_data : img_data_i;
  assign hit        = vld_pipe[1] && (FORCE_SPIKE || (rand_v < pix));
  assign xfer       = out_q.vld && spike_ready_i;
  assign stall      = out_q.vld && !spike_ready_i && hit;
  assign adv        = vld_pipe[1] && !stall;
  assign start_ok   = (state_q == ST_IDLE) && start_i && !done_q;
  assign drain_done = (state_q == ST_DRAIN) && (!out_q.vld || xfer);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok)         state_d = ST_RUN;
      ST_RUN:   if (vld_pipe == 2'b00) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done)       state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Issue stage and stage-1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      vld_pipe <= '0;
      s1_idx   <= '0;
      s1_hold  <= 1'b0;
      s1_data  <= '0;
    end else if (start_ok) begin
      addr_q   <= '0;
      vld_pipe <= 2'b01;
      s1_hold  <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (stall) begin
        if (!s1_hold) s1_data <= img_data_i;
        s1_hold <= 1'b1;
      end else begin
        s1_hold  <= 1'b0;
        vld_pipe <= {vld_pipe[0], vld_pipe[0] && (addr_q != LAST_IDX)};
        if (vld_pipe[0]) begin
          s1_idx <= addr_q;
          if (addr_q != LAST_IDX) addr_q <= addr_q + idx_t'(1);
        end
      end
    end else if (drain_done) begin
      addr_q <= '0;
    end
  end

  // Output register, spike counter and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= drain_done;
      if (start_ok) cnt_q <= '0;
      if (adv && hit) begin
        out_q.vld <= 1'b1;
        out_q.idx <= s1_idx;
        cnt_q     <= cnt_q + CNT_W'(1);
      end else if (xfer) begin
        out_q.vld <= 1'b0;
      end
    end
  end

  assign img_addr_o    = ADDR_W'(addr_q);
  assign spike_valid_o = out_q.vld;
  assign spike_idx_o   = out_q.idx;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign spike_count_o = cnt_q;
endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder: a forced-spike instance and a normal one share
// the stimulus; expected spike indices are queued and popped by a separate monitor.
module tb_spike_encoder;
  localparam int N = 196;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, set_seed = 1'b0, ready = 1'b1, sel = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] img [256];

  logic [9:0] addr_f, addr_n;
  logic [7:0] data_f, data_n, idx_f, idx_n;
  logic       v_f, v_n, busy_f, busy_n, done_f, done_n;
  logic [8:0] cnt_f, cnt_n;
  logic       st_f, st_n;

  int  n_tests = 0, n_fail = 0, done_cnt = 0;
  int  exp_q[$];
  bit  tog = 1'b0;
  bit  m_stl = 1'b0;
  int  m_held = 0;

  always #5 clk = ~clk;

  assign st_f = start & sel;
  assign st_n = start & ~sel;

  always @(posedge clk) begin
    data_f <= img[addr_f[7:0]];
    data_n <= img[addr_n[7:0]];
  end

  spike_encoder #(.NUM_PIXELS(N), .ADDR_W(10), .CNT_W(9), .FORCE_SPIKE(1'b1)) dut_f (
    .clk(clk), .rst(rst), .start_i(st_f), .seed_i(seed), .set_seed_i(set_seed),
    .img_addr_o(addr_f), .img_data_i(data_f), .spike_valid_o(v_f), .spike_idx_o(idx_f),
    .spike_ready_i(ready), .busy_o(busy_f), .done_o(done_f), .spike_count_o(cnt_f));

  spike_encoder #(.NUM_PIXELS(N), .ADDR_W(10), .CNT_W(9), .FORCE_SPIKE(1'b0)) dut_n (
    .clk(clk), .rst(rst), .start_i(st_n), .seed_i(seed), .set_seed_i(set_seed),
    .img_addr_o(addr_n), .img_data_i(data_n), .spike_valid_o(v_n), .spike_idx_o(idx_n),
    .spike_ready_i(ready), .busy_o(busy_n), .done_o(done_n), .spike_count_o(cnt_n));

  logic       v, busy, done;
  logic [7:0] idx;
  logic [8:0] cnt;
  assign v    = sel ? v_f    : v_n;
  assign idx  = sel ? idx_f  : idx_n;
  assign busy = sel ? busy_f : busy_n;
  assign done = sel ? done_f : done_n;
  assign cnt  = sel ? cnt_f  : cnt_n;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lnext(input logic [7:0] r);
    return r[0] ? ({1'b0, r[7:1]} ^ 8'hB8) : {1'b0, r[7:1]};
  endfunction

  // ready is either held high or toggled every cycle
  initial forever begin
    @(posedge clk); #1;
    ready = tog ? ~ready : 1'b1;
  end

  // Monitor: pops the scoreboard on every transfer, checks idx stability under backpressure
  initial forever begin
    @(negedge clk);
    if (rst) m_stl = 1'b0;
    else begin
      if (m_stl) chk("hold_idx", v ? int'(idx) : -1, m_held);
      if (v && ready) begin
        if (exp_q.size() == 0) chk("unexpected_spike", idx, -1);
        else                   chk("spike_idx", idx, exp_q.pop_front());
      end
      m_stl  = v && !ready;
      m_held = idx;
      if (done) done_cnt++;
    end
  end

  task automatic seed_pulse(input logic [7:0] s);
    @(posedge clk); #1; seed = s; set_seed = 1'b1;
    @(posedge clk); #1; set_seed = 1'b0;
  endtask

  task automatic run_pass(input bit s, input int exp_cnt, input int exp_cyc, input bit retrig,
                          input string nm);
    int cyc;
    @(posedge clk); #1; sel = s; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 0;
    while (cyc < 4000) begin
      @(posedge clk); cyc++; #1;
      if (s ? done_f : done_n) break;
    end
    chk({nm, "_done_seen"}, int'(cyc < 4000), 1);
    if (exp_cyc > 0) chk({nm, "_latency"}, cyc, exp_cyc);
    chk({nm, "_count"}, cnt, exp_cnt);
    chk({nm, "_busy_at_done"}, busy, 0);
    if (retrig) begin
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      chk({nm, "_start_on_done_ignored"}, busy, 0);
      chk({nm, "_count_held"}, cnt, exp_cnt);
    end
    @(negedge clk);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] r;
    int c, w, dc;
    int ks[3];
    ks[0] = 0; ks[1] = 50; ks[2] = N - 1;
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", v_f | v_n, 0);
    chk("rst_idx", idx_f | idx_n, 0);
    chk("rst_busy", busy_f | busy_n, 0);
    chk("rst_done", done_f | done_n, 0);
    chk("rst_count", cnt_f | cnt_n, 0);
    chk("rst_addr", addr_f | addr_n, 0);
    chk("rst_lfsr", dut_n.u_lfsr.rand_o, 1);

    // forced spikes, ready high: every index in order
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    run_pass(1'b1, N, N + 3, 1'b0, "force");

    // all-zero image never spikes; start during the done cycle is ignored
    run_pass(1'b0, 0, N + 3, 1'b1, "zero");

    // one bright pixel, zero seed behaves as 8'h01
    foreach (ks[j]) begin
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      img[ks[j]] = 8'hFF;
      seed_pulse(8'h00);
      r = 8'h01;
      for (int i = 0; i < ks[j]; i++) r = lnext(r);
      if (r != 8'hFF) exp_q.push_back(ks[j]);
      run_pass(1'b0, (r != 8'hFF) ? 1 : 0, N + 3, 1'b0, "bright");
    end

    // forced spikes with ready toggling; LFSR stepped once per pixel
    seed_pulse(8'h01);
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    tog = 1'b1;
    run_pass(1'b1, N, 0, 1'b0, "toggle");
    tog = 1'b0;
    r = 8'h01;
    for (int i = 0; i < N; i++) r = lnext(r);
    chk("lfsr_steps", dut_f.u_lfsr.rand_o, r);

    // same seed and image repeat identically, also under backpressure
    for (int i = 0; i < 256; i++) img[i] = 8'((i * 37 + 11) & 255);
    for (int rep = 0; rep < 3; rep++) begin
      seed_pulse(8'h5A);
      r = 8'h5A; c = 0;
      for (int i = 0; i < N; i++) begin
        if (r < img[i]) begin exp_q.push_back(i); c++; end
        r = lnext(r);
      end
      tog = (rep == 2);
      run_pass(1'b0, c, (rep == 2) ? 0 : N + 3, 1'b0, "pattern");
      tog = 1'b0;
    end

    // reset in the middle of a pass
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    @(posedge clk); #1; sel = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    w = 0;
    while (w < 1000) begin
      @(negedge clk); w++;
      if (v_f && idx_f == 8'd100) break;
    end
    chk("rst_reach_100", int'(w < 1000), 1);
    dc = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; exp_q.delete();
    @(negedge clk);
    chk("midrst_valid", v_f, 0);
    chk("midrst_idx", idx_f, 0);
    chk("midrst_busy", busy_f, 0);
    chk("midrst_count", cnt_f, 0);
    chk("midrst_addr", addr_f, 0);
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_cnt, dc);
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    run_pass(1'b1, N, N + 3, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
